// File: rtl/regfile_write_buffer_pkg.sv
// Shared types and constants for the register-file write buffer.
// The entry struct is sized by the package widths, so the top-level defaults must match them.
package regfile_write_buffer_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/regfile_write_buffer_bypass_lookup.sv
// Youngest-match search over pending write-buffer entries.
// Entries arrive age-ordered: index 0 is the oldest, so a later index overrides an earlier one.
module bypass_lookup
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  entry_t [DEPTH-1:0]      i_entries,
    input  logic   [DEPTH-1:0]      i_valid,
    input  logic   [ADDR_W-1:0]     i_addr,
    output logic                    o_hit,
    output logic   [DATA_W-1:0]     o_data
);

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_valid[k] && (i_entries[k].addr == i_addr) && (i_addr != REG_ZERO)) begin
                o_hit  = 1'b1;
                o_data = i_entries[k].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Buffers multi-cycle write-backs and replays them onto the register-file write port
// whenever the main pipeline leaves it idle; decode can bypass from pending entries.
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = regfile_write_buffer_pkg::DATA_W,
    parameter int ADDR_W = regfile_write_buffer_pkg::ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wbValid_i,
    output logic                      wbReady_o,
    input  logic [ADDR_W-1:0]         wbAddr_i,
    input  logic [DATA_W-1:0]         wbData_i,
    input  logic                      portBusy_i,
    output logic [ADDR_W-1:0]         regWriteAddr_o,
    output logic [DATA_W-1:0]         regWriteData_o,
    output logic                      regWriteEnable_o,
    input  logic [ADDR_W-1:0]         lookupAddr1_i,
    input  logic [ADDR_W-1:0]         lookupAddr2_i,
    output logic                      hit1_o,
    output logic                      hit2_o,
    output logic [DATA_W-1:0]         hitData1_o,
    output logic [DATA_W-1:0]         hitData2_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o
);
    import regfile_write_buffer_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;
    entry_t [DEPTH-1:0] w_aged;
    logic   [DEPTH-1:0] w_valid;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // r0 write-backs complete the handshake but never occupy a slot.
    assign w_push = wbValid_i && !w_full && (wbAddr_i != REG_ZERO);
    assign w_pop  = !w_empty && !portBusy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: slots are only observed through the count.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= '{addr: wbAddr_i, data: wbData_i};
    end

    assign w_head           = r_mem[r_rptr];
    assign regWriteEnable_o = w_pop;
    assign regWriteAddr_o   = w_empty ? '0 : w_head.addr;
    assign regWriteData_o   = w_empty ? '0 : w_head.data;

    assign wbReady_o = !w_full;
    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign count_o   = r_count;

    // Rotate storage into age order so the lookup's priority is a plain index order.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign w_aged[k]  = r_mem[r_rptr + PTR_W'(k)];
        assign w_valid[k] = (CNT_W'(k) < r_count);
    end

    bypass_lookup #(.DEPTH(DEPTH)) u_lookup1 (
        .i_entries (w_aged),
        .i_valid   (w_valid),
        .i_addr    (lookupAddr1_i),
        .o_hit     (hit1_o),
        .o_data    (hitData1_o)
    );

    bypass_lookup #(.DEPTH(DEPTH)) u_lookup2 (
        .i_entries (w_aged),
        .i_valid   (w_valid),
        .i_addr    (lookupAddr2_i),
        .o_hit     (hit2_o),
        .o_data    (hitData2_o)
    );

endmodule
